// File: rtl/sdc_pkg.sv
// Shared types for the SD-card DMA burst splitter:
// FSM state encoding, AXI response codes and response merging.
package sdc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WADDR,
    WDATA,
    WRESP,
    BRESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  function automatic logic [1:0] resp_max(
    input logic [1:0] a,
    input logic [1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic logic resp_err(input logic [1:0] r);
    return (r == RESP_SLVERR) || (r == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_burst_split_if.sv
// 32-bit AXI4 AW/W/B/AR/R bundle used on both sides of the splitter.
// Upstream DMA port uses the slave view, crossbar port the master view.
interface axi_burst_split_if;
  import sdc_pkg::*;

  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic        aw_valid;
  logic        aw_ready;

  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_last;
  logic        w_valid;
  logic        w_ready;

  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready;

  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        ar_valid;
  logic        ar_ready;

  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        r_valid;
  logic        r_ready;

  modport master (
    output aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_resp, b_valid,
    output b_ready,
    output ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_last, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_resp, b_valid,
    input  b_ready,
    input  ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_last, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/axi_burst_split.sv
// Splits AXI INCR bursts into sub-bursts that stay inside one blk-byte block.
// Define SPLIT_ERR_ABORT_EN to stop issuing chunks after an error response.
module axi_burst_split
  import sdc_pkg::*;
#(
  parameter int unsigned blk = 64
) (
  input  logic              clk,
  input  logic              rstn,
  axi_burst_split_if.slave  s,
  axi_burst_split_if.master m
);

  localparam int unsigned LB = $clog2(blk);

`ifdef SPLIT_ERR_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  state_t      state;
  logic [31:0] cur;
  logic [8:0]  rem;
  logic [7:0]  cnt;
  logic [7:0]  clen;
  logic [1:0]  bacc;
  logic        abrt;

  logic [10:0] span;
  logic [8:0]  room;
  logic [8:0]  n;
  logic [8:0]  n_m1;
  logic [1:0]  rmerge;
  logic [1:0]  bmerge;
  logic        unused_ok;

  // Beats left before the next block boundary, capped by what remains.
  always_comb begin
    span   = 11'(blk) - 11'(cur[LB-1:0]);
    room   = span[10:2];
    n      = (rem < room) ? rem : room;
    n_m1   = n - 9'd1;
    rmerge = resp_max(bacc, m.r_resp);
    bmerge = resp_max(bacc, m.b_resp);
  end

  assign unused_ok = ^{s.w_last, s.aw_size, s.aw_burst,
                       s.ar_size, s.ar_burst, span[1:0], n_m1[8]};

  always_comb begin
    s.ar_ready = (state == IDLE);
    s.aw_ready = (state == IDLE) && !s.ar_valid;

    m.ar_valid = (state == RADDR);
    m.ar_addr  = cur;
    m.ar_len   = n_m1[7:0];
    m.ar_size  = 3'd2;
    m.ar_burst = 2'd1;

    m.aw_valid = (state == WADDR);
    m.aw_addr  = cur;
    m.aw_len   = n_m1[7:0];
    m.aw_size  = 3'd2;
    m.aw_burst = 2'd1;

    // abrt: remaining read beats are produced locally
    s.r_valid = (state == RDATA) && (abrt || m.r_valid);
    s.r_data  = abrt ? 32'd0 : m.r_data;
    s.r_resp  = abrt ? bacc : m.r_resp;
    s.r_last  = abrt ? (rem == 9'd1)
                     : (m.r_last && (rem == 9'd0));
    m.r_ready = (state == RDATA) && !abrt && s.r_ready;

    m.w_valid = (state == WDATA) && !abrt && s.w_valid;
    m.w_data  = s.w_data;
    m.w_strb  = s.w_strb;
    m.w_last  = (cnt == clen);
    s.w_ready = (state == WDATA) && (abrt || m.w_ready);

    m.b_ready = (state == WRESP);
    s.b_valid = (state == BRESP);
    s.b_resp  = bacc;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      cur   <= '0;
      rem   <= '0;
      cnt   <= '0;
      clen  <= '0;
      bacc  <= RESP_OKAY;
      abrt  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          abrt <= 1'b0;
          bacc <= RESP_OKAY;
          if (s.ar_valid) begin
            cur   <= {s.ar_addr[31:2], 2'b00};
            rem   <= {1'b0, s.ar_len} + 9'd1;
            state <= RADDR;
          end else if (s.aw_valid) begin
            cur   <= {s.aw_addr[31:2], 2'b00};
            rem   <= {1'b0, s.aw_len} + 9'd1;
            state <= WADDR;
          end
        end
        RADDR: if (m.ar_ready) begin
          cur   <= cur + {21'd0, n, 2'b00};
          rem   <= rem - n;
          state <= RDATA;
        end
        RDATA: begin
          if (abrt) begin
            if (s.r_ready) begin
              rem <= rem - 9'd1;
              if (rem == 9'd1) state <= IDLE;
            end
          end else if (m.r_valid && s.r_ready) begin
            bacc <= rmerge;
            if (m.r_last) begin
              if (rem == 9'd0) state <= IDLE;
              else if (ABORT_EN && resp_err(rmerge)) abrt <= 1'b1;
              else state <= RADDR;
            end
          end
        end
        WADDR: if (m.aw_ready) begin
          cur   <= cur + {21'd0, n, 2'b00};
          rem   <= rem - n;
          clen  <= n_m1[7:0];
          cnt   <= 8'd0;
          state <= WDATA;
        end
        WDATA: begin
          if (abrt) begin
            if (s.w_valid) begin
              rem <= rem - 9'd1;
              if (rem == 9'd1) state <= BRESP;
            end
          end else if (s.w_valid && m.w_ready) begin
            cnt <= cnt + 8'd1;
            if (cnt == clen) state <= WRESP;
          end
        end
        WRESP: if (m.b_valid) begin
          bacc <= bmerge;
          if (rem == 9'd0) begin
            state <= BRESP;
          end else if (ABORT_EN && resp_err(bmerge)) begin
            abrt  <= 1'b1;
            state <= WDATA;
          end else begin
            state <= WADDR;
          end
        end
        BRESP: if (s.b_ready) begin
          bacc  <= RESP_OKAY;
          abrt  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_split.sv
// Randomized bench for axi_burst_split against a chunk-list reference model.
// Targets the default build (no SPLIT_ERR_ABORT_EN), blk = 64.
module tb_axi_burst_split;
  import sdc_pkg::*;

  localparam int unsigned BLK = 64;
  localparam logic [31:0] K = 32'h5A5A_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ch_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi_burst_split_if s_if ();
  axi_burst_split_if m_if ();

  axi_burst_split #(.blk(BLK)) dut (
    .clk  (clk),
    .rstn (rstn),
    .s    (s_if),
    .m    (m_if)
  );

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk the burst, cutting at each BLK-byte boundary.
  ch_t exp_ch[$];
  function automatic void model(input logic [31:0] a, input logic [7:0] len);
    int left;
    int n;
    logic [31:0] c;
    left = int'(len) + 1;
    c = a & ~32'd3;
    exp_ch.delete();
    while (left > 0) begin
      n = int'((BLK - (c % BLK)) / 4);
      if (n > left) n = left;
      exp_ch.push_back({c, 8'(n - 1)});
      c = c + 32'(4 * n);
      left -= n;
    end
  endfunction

  // Downstream memory model state
  ch_t mar_q[$];
  ch_t maw_q[$];
  ch_t rpend[$];
  logic [36:0] mw_q[$];
  logic [1:0] bresp_q[$];
  int bpend = 0;
  int b_hs_cyc = 0;

  initial begin
    m_if.ar_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && m_if.ar_valid && m_if.ar_ready) begin
        mar_q.push_back({m_if.ar_addr, m_if.ar_len});
        rpend.push_back({m_if.ar_addr, m_if.ar_len});
        chk("ar_size", 64'(m_if.ar_size), 64'd2);
        chk("ar_burst", 64'(m_if.ar_burst), 64'd1);
      end
      @(posedge clk); #1;
      m_if.ar_ready = rstn && ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int bi;
    bit hs;
    logic [31:0] a;
    bi = 0;
    m_if.r_valid = 1'b0;
    m_if.r_data = '0;
    m_if.r_resp = '0;
    m_if.r_last = 1'b0;
    forever begin
      hs = 1'b0;
      @(negedge clk);
      if (rstn && m_if.r_valid && m_if.r_ready) begin
        hs = 1'b1;
        if (m_if.r_last) begin
          void'(rpend.pop_front());
          bi = 0;
        end else begin
          bi++;
        end
      end
      @(posedge clk); #1;
      if (!rstn) begin
        rpend.delete();
        bi = 0;
        m_if.r_valid = 1'b0;
      end else if (!m_if.r_valid || hs) begin
        if (rpend.size() > 0 && $urandom_range(0, 3) != 0) begin
          a = rpend[0].addr + 32'(4 * bi);
          m_if.r_valid = 1'b1;
          m_if.r_data = a ^ K;
          m_if.r_resp = a[5:4];
          m_if.r_last = (bi == int'(rpend[0].len));
        end else begin
          m_if.r_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    m_if.aw_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && m_if.aw_valid && m_if.aw_ready) begin
        maw_q.push_back({m_if.aw_addr, m_if.aw_len});
        chk("aw_size", 64'(m_if.aw_size), 64'd2);
        chk("aw_burst", 64'(m_if.aw_burst), 64'd1);
      end
      @(posedge clk); #1;
      m_if.aw_ready = rstn && ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    m_if.w_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && m_if.w_valid && m_if.w_ready) begin
        mw_q.push_back({m_if.w_strb, m_if.w_last, m_if.w_data});
        if (m_if.w_last) bpend++;
      end
      @(posedge clk); #1;
      m_if.w_ready = rstn && ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    bit hs;
    m_if.b_valid = 1'b0;
    m_if.b_resp = '0;
    forever begin
      hs = 1'b0;
      @(negedge clk);
      if (rstn && m_if.b_valid && m_if.b_ready) begin
        bpend--;
        b_hs_cyc = cyc;
        hs = 1'b1;
      end
      @(posedge clk); #1;
      if (!rstn) begin
        bpend = 0;
        m_if.b_valid = 1'b0;
      end else if (!m_if.b_valid || hs) begin
        if (bpend > 0 && $urandom_range(0, 2) != 0) begin
          m_if.b_valid = 1'b1;
          m_if.b_resp = (bresp_q.size() > 0) ? bresp_q.pop_front() : RESP_OKAY;
        end else begin
          m_if.b_valid = 1'b0;
        end
      end
    end
  end

  task automatic cmp_chunks(input string tag, input ch_t got[$]);
    chk({tag, "_count"}, 64'(got.size()), 64'(exp_ch.size()));
    for (int k = 0; k < exp_ch.size() && k < got.size(); k++) begin
      chk({tag, "_addr"}, 64'(got[k].addr), 64'(exp_ch[k].addr));
      chk({tag, "_len"}, 64'(got[k].len), 64'(exp_ch[k].len));
    end
  endtask

  task automatic ar_req(input logic [31:0] a, input logic [7:0] len);
    int t;
    t = 0;
    s_if.ar_addr = a;
    s_if.ar_len = len;
    s_if.ar_valid = 1'b1;
    @(negedge clk);
    while (!s_if.ar_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("ar_accept", 64'(s_if.ar_ready), 64'd1);
    @(posedge clk); #1;
    s_if.ar_valid = 1'b0;
    @(negedge clk);
    chk("ar_latency", 64'(m_if.ar_valid), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic aw_req(input logic [31:0] a, input logic [7:0] len);
    int t;
    t = 0;
    s_if.aw_addr = a;
    s_if.aw_len = len;
    s_if.aw_valid = 1'b1;
    @(negedge clk);
    while (!s_if.aw_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("aw_accept", 64'(s_if.aw_ready), 64'd1);
    @(posedge clk); #1;
    s_if.aw_valid = 1'b0;
    @(negedge clk);
    chk("aw_latency", 64'(m_if.aw_valid), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic rd_data(input logic [31:0] a, input logic [7:0] len);
    int i;
    int t;
    logic [31:0] ea;
    i = 0;
    t = 0;
    while (i <= int'(len) && t < 20000) begin
      s_if.r_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (s_if.r_valid && s_if.r_ready) begin
        ea = (a & ~32'd3) + 32'(4 * i);
        chk("r_data", 64'(s_if.r_data), 64'(ea ^ K));
        chk("r_resp", 64'(s_if.r_resp), 64'(ea[5:4]));
        chk("r_last", 64'(s_if.r_last), 64'(i == int'(len)));
        i++;
      end
      @(posedge clk); #1;
      t++;
    end
    s_if.r_ready = 1'b0;
    chk("r_beats", 64'(i), 64'(int'(len) + 1));
    @(negedge clk);
    chk("r_idle", 64'(s_if.r_valid), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] len);
    model(a, len);
    mar_q.delete();
    ar_req(a, len);
    rd_data(a, len);
    cmp_chunks("ar", mar_q);
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] len,
                    input logic [1:0] rs[$], input bit pre);
    int i;
    int t;
    int pos;
    bit hs;
    bit seen;
    bit first;
    logic [1:0] r;
    logic [1:0] eb;
    logic [35:0] wd[$];
    bit lastv[$];
    model(a, len);
    maw_q.delete();
    mw_q.delete();
    bresp_q.delete();
    eb = RESP_OKAY;
    foreach (exp_ch[k]) begin
      r = (k < rs.size()) ? rs[k] : 2'($urandom_range(0, 3));
      bresp_q.push_back(r);
      if (r > eb) eb = r;
    end
    if (pre) s_if.aw_valid = 1'b0;
    else aw_req(a, len);
    i = 0;
    t = 0;
    while (i <= int'(len) && t < 20000) begin
      if (!s_if.w_valid && $urandom_range(0, 3) != 0) begin
        s_if.w_valid = 1'b1;
        s_if.w_data = $urandom;
        s_if.w_strb = 4'($urandom);
        s_if.w_last = (i == int'(len));
      end
      hs = 1'b0;
      @(negedge clk);
      if (s_if.w_valid && s_if.w_ready) begin
        wd.push_back({s_if.w_strb, s_if.w_data});
        i++;
        hs = 1'b1;
      end
      @(posedge clk); #1;
      t++;
      if (hs) s_if.w_valid = 1'b0;
    end
    chk("w_sent", 64'(i), 64'(int'(len) + 1));
    seen = 1'b0;
    first = 1'b1;
    t = 0;
    while (!seen && t < 2000) begin
      s_if.b_ready = ($urandom_range(0, 1) != 0);
      @(negedge clk);
      if (s_if.b_valid && first) begin
        chk("b_latency", 64'(cyc), 64'(b_hs_cyc + 1));
        first = 1'b0;
      end
      if (s_if.b_valid && s_if.b_ready) begin
        chk("b_resp", 64'(s_if.b_resp), 64'(eb));
        seen = 1'b1;
      end
      @(posedge clk); #1;
      t++;
    end
    s_if.b_ready = 1'b0;
    chk("b_seen", 64'(seen), 64'd1);
    cmp_chunks("aw", maw_q);
    for (int j = 0; j <= int'(len); j++) lastv.push_back(1'b0);
    pos = 0;
    foreach (exp_ch[k]) begin
      pos += int'(exp_ch[k].len) + 1;
      lastv[pos - 1] = 1'b1;
    end
    chk("w_count", 64'(mw_q.size()), 64'(int'(len) + 1));
    for (int j = 0; j < mw_q.size() && j < wd.size(); j++) begin
      chk("w_data", 64'(mw_q[j][31:0]), 64'(wd[j][31:0]));
      chk("w_strb", 64'(mw_q[j][36:33]), 64'(wd[j][35:32]));
      chk("w_last", 64'(mw_q[j][32]), 64'(lastv[j]));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] none[$];
    logic [1:0] rs2[$];
    int i;
    int t;
    s_if.ar_addr = '0; s_if.ar_len = '0;
    s_if.ar_size = 3'd2; s_if.ar_burst = 2'd1;
    s_if.ar_valid = 1'b0;
    s_if.aw_addr = '0; s_if.aw_len = '0;
    s_if.aw_size = 3'd2; s_if.aw_burst = 2'd1;
    s_if.aw_valid = 1'b0;
    s_if.w_data = '0; s_if.w_strb = '0;
    s_if.w_last = 1'b0; s_if.w_valid = 1'b0;
    s_if.b_ready = 1'b0;
    s_if.r_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ar_ready", 64'(s_if.ar_ready), 64'd1);
    chk("rst_aw_ready", 64'(s_if.aw_ready), 64'd1);
    chk("rst_m_arvalid", 64'(m_if.ar_valid), 64'd0);
    chk("rst_m_awvalid", 64'(m_if.aw_valid), 64'd0);
    chk("rst_m_wvalid", 64'(m_if.w_valid), 64'd0);
    chk("rst_s_bvalid", 64'(s_if.b_valid), 64'd0);
    chk("rst_s_rvalid", 64'(s_if.r_valid), 64'd0);
    chk("rst_m_bready", 64'(m_if.b_ready), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    rd(32'h0000_1000, 8'd15);
    rd(32'h0000_1038, 8'd7);
    rd(32'h0000_2000, 8'd255);
    rd(32'h0000_2024, 8'd255);
    rs2.delete();
    rs2.push_back(RESP_OKAY);
    rs2.push_back(RESP_SLVERR);
    wr(32'h0000_3030, 8'd7, rs2, 1'b0);

    // Simultaneous AR and AW: the read goes first.
    model(32'h0000_5010, 8'd9);
    mar_q.delete();
    maw_q.delete();
    s_if.ar_addr = 32'h0000_5010; s_if.ar_len = 8'd9; s_if.ar_valid = 1'b1;
    s_if.aw_addr = 32'h0000_4004; s_if.aw_len = 8'd5; s_if.aw_valid = 1'b1;
    @(negedge clk);
    chk("sim_ar_ready", 64'(s_if.ar_ready), 64'd1);
    chk("sim_aw_ready", 64'(s_if.aw_ready), 64'd0);
    @(posedge clk); #1;
    s_if.ar_valid = 1'b0;
    rd_data(32'h0000_5010, 8'd9);
    cmp_chunks("sim_ar", mar_q);
    chk("sim_no_aw", 64'(maw_q.size()), 64'd0);
    wr(32'h0000_4004, 8'd5, none, 1'b1);

    // Reset while the third write beat is presented.
    model(32'h0000_3030, 8'd7);
    maw_q.delete();
    mw_q.delete();
    bresp_q.delete();
    aw_req(32'h0000_3030, 8'd7);
    s_if.w_valid = 1'b1;
    s_if.w_strb = 4'hF;
    s_if.w_data = $urandom;
    s_if.w_last = 1'b0;
    i = 0;
    t = 0;
    while (i < 2 && t < 2000) begin
      @(negedge clk);
      if (s_if.w_ready) i++;
      @(posedge clk); #1;
      s_if.w_data = $urandom;
      t++;
    end
    chk("rst_pre_beats", 64'(i), 64'd2);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_m_awvalid", 64'(m_if.aw_valid), 64'd0);
    chk("mid_rst_m_wvalid", 64'(m_if.w_valid), 64'd0);
    chk("mid_rst_m_arvalid", 64'(m_if.ar_valid), 64'd0);
    chk("mid_rst_s_bvalid", 64'(s_if.b_valid), 64'd0);
    chk("mid_rst_s_rvalid", 64'(s_if.r_valid), 64'd0);
    chk("mid_rst_s_wready", 64'(s_if.w_ready), 64'd0);
    @(posedge clk); #1;
    s_if.w_valid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    rd(32'h0000_6008, 8'd20);

    // Address wrap past 2^32.
    rd(32'hFFFF_FFF0, 8'd7);
    wr(32'hFFFF_FFE4, 8'd20, none, 1'b0);

    for (int it = 0; it < 24; it++) begin
      logic [31:0] a;
      logic [7:0] l;
      a = $urandom;
      if (it % 4 == 3) a = 32'hFFFF_FF00 | (a & 32'hFF);
      l = (it % 3 == 0) ? 8'($urandom_range(0, 255))
                        : 8'($urandom_range(0, 24));
      if ($urandom_range(0, 1) != 0) rd(a, l);
      else wr(a, l, none, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
